nbit_accumulator: RTL
=====================

NBIT_ACCUMULATOR -- requirements
Module: nbit_accumulator

Interface
REQ-001 Parameter N, default 4: input sample width in bits.
REQ-002 Parameter ACC_W, default 8: accumulator and result width in bits; ACC_W SHALL be at least N.
REQ-003 Parameter FRAME, default 4: samples per frame; FRAME SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  in_data holds a valid sample.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  N  unsigned sample.
REQ-010 out_valid  output  1  out_sum holds a completed frame sum.
REQ-011 out_ready  input  1  downstream accepts out_sum this cycle.
REQ-012 out_sum  output  ACC_W  saturated unsigned sum of one frame.
REQ-013 out_ovf  output  1  at least one add in this frame saturated.

Function
REQ-014 The FSM SHALL have three states: IDLE (acc=0, cnt=0), ACCUM (frame in progress) and HOLD (result presented).
REQ-015 A sample SHALL be accepted only on a cycle where in_valid=1, in_ready=1 and clear=0.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; there is no bypass from HOLD to a new frame.
REQ-017 On accept: acc <= sat(acc + zero-extended in_data), and cnt <= cnt+1.
REQ-018 On the first accept in IDLE the FSM SHALL go to ACCUM; with FRAME=1 it SHALL go directly to HOLD.
REQ-019 The accept that makes cnt reach FRAME SHALL move the FSM to HOLD, with out_valid=1 on the next cycle (latency 1 cycle after the last beat).
REQ-020 sat(): if the ACC_W+1-bit sum has its MSB set, acc SHALL become 2^ACC_W-1 and the ovf flag SHALL be set.
REQ-021 The ovf flag SHALL stay set until the frame is consumed or cleared.
REQ-022 out_sum and out_ovf SHALL be driven from registers and held stable while out_valid=1 and out_ready=0.
REQ-023 In HOLD, out_valid=1 with out_ready=1 SHALL return the FSM to IDLE and clear acc, cnt and ovf; out_valid SHALL be 0 on the next cycle.
REQ-024 out_valid SHALL be 0 in IDLE and ACCUM, and out_sum/out_ovf SHALL be 0 there.
REQ-025 clear=1 SHALL take priority over accept and output handshake in any state, forcing IDLE with acc=0, cnt=0, ovf=0 and out_valid=0 next cycle.
REQ-026 clear=1 SHALL cause any sample presented in the same cycle to be dropped.
REQ-027 in_valid=0 in ACCUM SHALL hold all state; there is no timeout.
REQ-028 cnt SHALL be $clog2(FRAME+1) bits wide and SHALL never wrap, because FRAME is terminal.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state=IDLE, acc=0, cnt=0 and ovf=0.
REQ-030 rst_n=0 SHALL immediately force out_valid=0, out_sum=0 and out_ovf=0, with in_ready=1 once rst_n deasserts.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result.
REQ-032 Reset deassertion SHALL be synchronised externally; this block does not synchronise it.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, ACCUM, HOLD).
REQ-034 The same package SHALL hold the default parameter constants (N=4, ACC_W=8, FRAME=4).
REQ-035 The addition SHALL use one instance of the existing nbit_adder with n=ACC_W; its carry-out bit drives the saturation decision.
REQ-036 No other sub-modules SHALL be used; the FSM, counter and registers are local.

Verification
REQ-037 Reset then in_data=3,5,7,1 with out_ready=1 -> out_valid pulses one cycle after 4th accept; out_sum=16, out_ovf=0.
REQ-038 N=4, ACC_W=5: in_data=15,15,15,1 -> out_sum=31, out_ovf=1.
REQ-039 Frame complete, out_ready=0 for 5 cycles -> out_valid/out_sum stable and in_ready=0; raise out_ready -> IDLE next cycle.
REQ-040 clear=1 after 2 accepts with in_valid=1 -> sample dropped; next frame 2,2,2,2 -> out_sum=8.
REQ-041 rst_n pulsed low asynchronously in HOLD -> out_valid=0 immediately, and the next frame sums from 0.
REQ-042 Random in_valid/out_ready gaps over 1000 frames -> every out_sum matches the saturating reference model.

Source files
------------

// File: rtl/nbit_accumulator_pkg.sv
// Shared types and default parameters for the frame-summing accumulator.
package nbit_accumulator_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_ACC_W = 8;
    localparam int unsigned DEF_FRAME = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/nbit_accumulator_adder.sv
// Plain n-bit ripple adder with carry in/out; carry-out flags unsigned overflow.
module nbit_adder #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = (n+1)'(a) + (n+1)'(b) + (n+1)'(cin);

endmodule

// File: rtl/nbit_accumulator.sv
// Sums FRAME unsigned samples with saturation and presents the result
// through a valid/ready handshake; clear aborts the frame in any state.
module nbit_accumulator
    import nbit_accumulator_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned FRAME = DEF_FRAME
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned      CNT_W    = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_cout;
    logic [ACC_W-1:0]   sat_sum;
    logic               accept;

    nbit_adder #(
        .n (ACC_W)
    ) u_adder (
        .a    (acc_q),
        .b    (ACC_W'(in_data)),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign sat_sum = add_cout ? ACC_MAX : add_sum;
    assign accept  = in_valid & in_ready_q & ~clear;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Next-state: clear outranks both the input accept and the output handshake
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = sat_sum;
                        ovf_d   = ovf_q | add_cout;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ACCUM;
                        if (cnt_q == LAST_CNT) begin
                            state_d     = HOLD;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                            out_sum_d   = sat_sum;
                            out_ovf_d   = ovf_q | add_cout;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_sum_d   = '0;
                        out_ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule
